mem_arbiter: RTL and testbench

- Two-master arbiter that shares the single memory port (address, write data, read/write enables, read data) between the black_bean core (master 0) and a second requester (master 1), e.g. a program loader or debug port.
- Sits between the requesters and the memory array.
- Serialises single-beat accesses with a req/ack handshake.
- Selects between masters by round-robin or fixed priority.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one single-beat memory port between the core
// (master 0) and a secondary requester (master 1) using a req/ack handshake.
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DATA_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DATA_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  output logic                  mem_w_en,
  output logic                  mem_r_en,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  winner;
  logic                  done;

  // A lone requester always wins; a tie goes to master 0 or to whoever was not served last.
  always_comb begin
    if (m0_req && m1_req) begin
      winner = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      winner = m1_req;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          grant_d = winner;
          last_d  = winner;
          addr_d  = winner ? m1_addr  : m0_addr;
          wdata_d = winner ? m1_wdata : m0_wdata;
          wen_d   = winner ? m1_we    : m0_we;
          ren_d   = winner ? ~m1_we   : ~m0_we;
        end
      end
      ACCESS:  state_d = wen_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // An asserted reset suppresses the completing ack so an aborted access is never acknowledged.
  assign done = rst_n && (((state_q == ACCESS) && wen_q) || (state_q == RDATA));

  assign m0_ack     = done && !grant_q;
  assign m1_ack     = done && grant_q;
  assign m0_rdata   = mem_r_data;
  assign m1_rdata   = mem_r_data;
  assign mem_addr   = addr_q;
  assign mem_w_data = wdata_q;
  assign mem_w_en   = wen_q;
  assign mem_r_en   = ren_q;
  assign busy       = (state_q != IDLE);
  assign grant      = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance,
// each backed by a small behavioural memory.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          rrM0Req, rrM0We, rrM1Req, rrM1We;
  logic [DW-1:0] rrM0Addr, rrM0Wdata, rrM1Addr, rrM1Wdata;
  logic          rrM0Ack, rrM1Ack, rrMemWEn, rrMemREn, rrBusy, rrGrant;
  logic [DW-1:0] rrM0Rdata, rrM1Rdata, rrMemAddr, rrMemWData, rrMemRData;

  logic          fpM0Req, fpM0We, fpM1Req, fpM1We;
  logic [DW-1:0] fpM0Addr, fpM0Wdata, fpM1Addr, fpM1Wdata;
  logic          fpM0Ack, fpM1Ack, fpMemWEn, fpMemREn, fpBusy, fpGrant;
  logic [DW-1:0] fpM0Rdata, fpM1Rdata, fpMemAddr, fpMemWData, fpMemRData;

  mem_arbiter #(.DATA_WIDTH(DW), .FIXED_PRIO(1'b0)) dutRr (
    .clk(clk), .rst_n(rst_n),
    .m0_req(rrM0Req), .m0_we(rrM0We), .m0_addr(rrM0Addr), .m0_wdata(rrM0Wdata),
    .m0_ack(rrM0Ack), .m0_rdata(rrM0Rdata),
    .m1_req(rrM1Req), .m1_we(rrM1We), .m1_addr(rrM1Addr), .m1_wdata(rrM1Wdata),
    .m1_ack(rrM1Ack), .m1_rdata(rrM1Rdata),
    .mem_addr(rrMemAddr), .mem_w_data(rrMemWData), .mem_w_en(rrMemWEn),
    .mem_r_en(rrMemREn), .mem_r_data(rrMemRData), .busy(rrBusy), .grant(rrGrant)
  );

  mem_arbiter #(.DATA_WIDTH(DW), .FIXED_PRIO(1'b1)) dutFp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(fpM0Req), .m0_we(fpM0We), .m0_addr(fpM0Addr), .m0_wdata(fpM0Wdata),
    .m0_ack(fpM0Ack), .m0_rdata(fpM0Rdata),
    .m1_req(fpM1Req), .m1_we(fpM1We), .m1_addr(fpM1Addr), .m1_wdata(fpM1Wdata),
    .m1_ack(fpM1Ack), .m1_rdata(fpM1Rdata),
    .mem_addr(fpMemAddr), .mem_w_data(fpMemWData), .mem_w_en(fpMemWEn),
    .mem_r_en(fpMemREn), .mem_r_data(fpMemRData), .busy(fpBusy), .grant(fpGrant)
  );

  // Behavioural memories: read data registered one cycle after mem_r_en, plus a preload path.
  logic [DW-1:0] memRr [256];
  logic [DW-1:0] memFp [256];
  logic          loadEn;
  logic [7:0]    loadAddr;
  logic [DW-1:0] loadData;

  always @(posedge clk) begin
    if (loadEn) begin
      memRr[loadAddr] <= loadData;
      memFp[loadAddr] <= loadData;
    end else begin
      if (rrMemWEn) memRr[rrMemAddr[7:0]] <= rrMemWData;
      if (fpMemWEn) memFp[fpMemAddr[7:0]] <= fpMemWData;
    end
    if (rrMemREn) rrMemRData <= memRr[rrMemAddr[7:0]];
    if (fpMemREn) fpMemRData <= memFp[fpMemAddr[7:0]];
  end

  typedef struct {
    logic          m0Req;
    logic          m0We;
    logic [DW-1:0] m0Addr;
    logic [DW-1:0] m0Wdata;
    logic          m1Req;
    logic          m1We;
    logic [DW-1:0] m1Addr;
    logic [DW-1:0] m1Wdata;
    logic          expM0Ack;
    logic          expM1Ack;
    logic          expWEn;
    logic          expREn;
    logic          expBusy;
    logic          expGrant;
    logic [DW-1:0] expAddr;
    logic [DW-1:0] expWData;
    logic          chkRd;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t vecs [14];
  int   checks = 0;
  int   errors = 0;

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkWord(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rrM0Req = v.m0Req; rrM0We = v.m0We; rrM0Addr = v.m0Addr; rrM0Wdata = v.m0Wdata;
    rrM1Req = v.m1Req; rrM1We = v.m1We; rrM1Addr = v.m1Addr; rrM1Wdata = v.m1Wdata;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkBit({tag, ".m0_ack"}, rrM0Ack, v.expM0Ack);
    checkBit({tag, ".m1_ack"}, rrM1Ack, v.expM1Ack);
    checkBit({tag, ".mem_w_en"}, rrMemWEn, v.expWEn);
    checkBit({tag, ".mem_r_en"}, rrMemREn, v.expREn);
    checkBit({tag, ".busy"}, rrBusy, v.expBusy);
    checkBit({tag, ".grant"}, rrGrant, v.expGrant);
    checkWord({tag, ".mem_addr"}, rrMemAddr, v.expAddr);
    checkWord({tag, ".mem_w_data"}, rrMemWData, v.expWData);
    if (v.chkRd) begin
      if (v.expM0Ack) checkWord({tag, ".m0_rdata"}, rrM0Rdata, v.expRdata);
      else            checkWord({tag, ".m1_rdata"}, rrM1Rdata, v.expRdata);
    end
  endtask

  task automatic idleAll();
    rrM0Req = 0; rrM0We = 0; rrM0Addr = '0; rrM0Wdata = '0;
    rrM1Req = 0; rrM1We = 0; rrM1Addr = '0; rrM1Wdata = '0;
    fpM0Req = 0; fpM0We = 0; fpM0Addr = '0; fpM0Wdata = '0;
    fpM1Req = 0; fpM1We = 0; fpM1Addr = '0; fpM1Wdata = '0;
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(posedge clk); #1;
    loadEn = 1'b0;
  endtask

  task automatic resetBoth();
    rst_n = 1'b0;
    idleAll();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int rrCnt [2];
    int fpCnt [2];
    int rrN, fpN, k, lastAckCyc;
    logic rrPrev, fpPrev;
    logic rrExp, fpExp;

    vecs[0]  = '{H,H,16'h0010,16'hBEEF, L,L,16'h0000,16'h0000, L,L,L,L,L,L,16'h0000,16'h0000,L,16'h0000};
    vecs[1]  = '{H,H,16'h0010,16'hBEEF, L,L,16'h0000,16'h0000, H,L,H,L,H,L,16'h0010,16'hBEEF,L,16'h0000};
    vecs[2]  = '{L,L,16'h0000,16'h0000, H,L,16'h0004,16'h0000, L,L,L,L,L,L,16'h0010,16'hBEEF,L,16'h0000};
    vecs[3]  = '{L,L,16'h0000,16'h0000, H,L,16'h0004,16'h0000, L,L,L,H,H,H,16'h0004,16'h0000,L,16'h0000};
    vecs[4]  = '{L,L,16'h0000,16'h0000, H,L,16'h0004,16'h0000, L,H,L,L,H,H,16'h0004,16'h0000,H,16'h1234};
    vecs[5]  = '{H,L,16'h0010,16'h0000, L,L,16'h0000,16'h0000, L,L,L,L,L,H,16'h0004,16'h0000,L,16'h0000};
    vecs[6]  = '{H,L,16'h0010,16'h0000, L,L,16'h0000,16'h0000, L,L,L,H,H,L,16'h0010,16'h0000,L,16'h0000};
    vecs[7]  = '{H,L,16'h0010,16'h0000, L,L,16'h0000,16'h0000, H,L,L,L,H,L,16'h0010,16'h0000,H,16'hBEEF};
    vecs[8]  = '{H,H,16'h0020,16'h5555, L,L,16'h0000,16'h0000, L,L,L,L,L,L,16'h0010,16'h0000,L,16'h0000};
    vecs[9]  = '{L,H,16'h0020,16'h5555, L,L,16'h0000,16'h0000, H,L,H,L,H,L,16'h0020,16'h5555,L,16'h0000};
    vecs[10] = '{L,L,16'h0000,16'h0000, L,L,16'h0000,16'h0000, L,L,L,L,L,L,16'h0020,16'h5555,L,16'h0000};
    vecs[11] = '{H,L,16'h0020,16'h0000, L,L,16'h0000,16'h0000, L,L,L,L,L,L,16'h0020,16'h5555,L,16'h0000};
    vecs[12] = '{H,L,16'h0020,16'h0000, L,L,16'h0000,16'h0000, L,L,L,H,H,L,16'h0020,16'h0000,L,16'h0000};
    vecs[13] = '{H,L,16'h0020,16'h0000, L,L,16'h0000,16'h0000, H,L,L,L,H,L,16'h0020,16'h0000,H,16'h5555};

    rst_n = 1'b0;
    loadEn = 1'b0; loadAddr = '0; loadData = '0;
    idleAll();
    loadWord(8'h04, 16'h1234);
    loadWord(8'h00, 16'h1000);
    loadWord(8'h01, 16'h1001);
    loadWord(8'h02, 16'h1002);
    resetBoth();

    $display("[TB] reset values of fixed-priority instance");
    @(negedge clk); #1;
    checkBit("fpResetBusy", fpBusy, 1'b0);
    checkBit("fpResetGrant", fpGrant, 1'b0);
    checkWord("fpResetAddr", fpMemAddr, 16'h0000);
    checkBit("fpResetWEn", fpMemWEn, 1'b0);

    $display("[TB] table vectors on round-robin instance");
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
    end
    checkWord("memWriteBeef", memRr[8'h10], 16'hBEEF);

    $display("[TB] both masters, four writes each");
    resetBoth();
    rrM0Req = 1; rrM0We = 1; rrM0Addr = 16'h0040; rrM0Wdata = 16'hA000;
    rrM1Req = 1; rrM1We = 1; rrM1Addr = 16'h0050; rrM1Wdata = 16'hB000;
    fpM0Req = 1; fpM0We = 1; fpM0Addr = 16'h0040; fpM0Wdata = 16'hA000;
    fpM1Req = 1; fpM1We = 1; fpM1Addr = 16'h0050; fpM1Wdata = 16'hB000;
    rrCnt = '{0, 0}; fpCnt = '{0, 0};
    rrN = 0; fpN = 0; rrPrev = 0; fpPrev = 0;
    for (int cyc = 0; cyc < 60 && (rrN < 8 || fpN < 8); cyc++) begin
      @(negedge clk); #1;
      checkBit("burstRrExclusive", rrMemWEn & rrMemREn, 1'b0);
      rrExp = rrN[0];
      fpExp = (fpN >= 4);
      if (rrM0Ack || rrM1Ack) begin
        checkBit("burstRrPulse", rrPrev, 1'b0);
        checkBit("burstRrGrant", rrGrant, rrExp);
        checkBit("burstRrAckM1", rrM1Ack, rrExp);
        checkBit("burstRrAckM0", rrM0Ack, ~rrExp);
      end
      if (fpM0Ack || fpM1Ack) begin
        checkBit("burstFpPulse", fpPrev, 1'b0);
        checkBit("burstFpGrant", fpGrant, fpExp);
        checkBit("burstFpAckM1", fpM1Ack, fpExp);
        checkBit("burstFpAckM0", fpM0Ack, ~fpExp);
      end
      rrPrev = rrM0Ack | rrM1Ack;
      fpPrev = fpM0Ack | fpM1Ack;
      @(posedge clk); #1;
      if (rrPrev) begin
        rrN++;
        if (rrExp) begin
          rrCnt[1]++;
          if (rrCnt[1] == 4) rrM1Req = 0;
          else begin rrM1Addr = 16'(16'h0050 + rrCnt[1]); rrM1Wdata = 16'(16'hB000 + rrCnt[1]); end
        end else begin
          rrCnt[0]++;
          if (rrCnt[0] == 4) rrM0Req = 0;
          else begin rrM0Addr = 16'(16'h0040 + rrCnt[0]); rrM0Wdata = 16'(16'hA000 + rrCnt[0]); end
        end
      end
      if (fpPrev) begin
        fpN++;
        if (fpExp) begin
          fpCnt[1]++;
          if (fpCnt[1] == 4) fpM1Req = 0;
          else begin fpM1Addr = 16'(16'h0050 + fpCnt[1]); fpM1Wdata = 16'(16'hB000 + fpCnt[1]); end
        end else begin
          fpCnt[0]++;
          if (fpCnt[0] == 4) fpM0Req = 0;
          else begin fpM0Addr = 16'(16'h0040 + fpCnt[0]); fpM0Wdata = 16'(16'hA000 + fpCnt[0]); end
        end
      end
    end
    checkInt("burstRrAckCount", rrN, 8);
    checkInt("burstFpAckCount", fpN, 8);
    checkWord("burstRrMem43", memRr[8'h43], 16'hA003);
    checkWord("burstRrMem53", memRr[8'h53], 16'hB003);
    checkWord("burstFpMem40", memFp[8'h40], 16'hA000);
    checkWord("burstFpMem52", memFp[8'h52], 16'hB002);
    idleAll();
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset during a master 0 read");
    rrM0Req = 1; rrM0We = 0; rrM0Addr = 16'h0004;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkBit("rstNoAck", rrM0Ack, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rrM0Req = 1; rrM0We = 1; rrM0Addr = 16'h0060; rrM0Wdata = 16'h1111;
    rrM1Req = 1; rrM1We = 1; rrM1Addr = 16'h0061; rrM1Wdata = 16'h2222;
    @(negedge clk); #1;
    checkBit("rstAck0", rrM0Ack, 1'b0);
    checkBit("rstAck1", rrM1Ack, 1'b0);
    checkBit("rstBusy", rrBusy, 1'b0);
    checkBit("rstGrant", rrGrant, 1'b0);
    checkBit("rstWEn", rrMemWEn, 1'b0);
    checkBit("rstREn", rrMemREn, 1'b0);
    checkWord("rstAddr", rrMemAddr, 16'h0000);
    checkWord("rstWData", rrMemWData, 16'h0000);
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkBit("postRstGrant", rrGrant, 1'b0);
    checkBit("postRstAck0", rrM0Ack, 1'b1);
    checkBit("postRstAck1", rrM1Ack, 1'b0);
    checkWord("postRstAddr", rrMemAddr, 16'h0060);
    @(posedge clk); #1;
    rrM0Req = 0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkBit("pendingM1Ack", rrM1Ack, 1'b1);
    checkBit("pendingM1Grant", rrGrant, 1'b1);
    @(posedge clk); #1;
    rrM1Req = 0;
    @(posedge clk); #1;

    $display("[TB] back-to-back master 0 reads");
    rrM0Req = 1; rrM0We = 0; rrM0Addr = 16'h0000;
    k = 0;
    lastAckCyc = -1;
    for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
      @(negedge clk); #1;
      checkBit("b2bNoWrite", rrMemWEn, 1'b0);
      if (rrM0Ack) begin
        checkWord("b2bData", rrM0Rdata, 16'(16'h1000 + k));
        if (k == 0) checkInt("b2bFirstLatency", cyc, 2);
        else        checkInt("b2bSpacing", cyc - lastAckCyc, 3);
        lastAckCyc = cyc;
        k++;
        @(posedge clk); #1;
        if (k < 3) rrM0Addr = 16'(k);
        else       rrM0Req = 0;
      end
    end
    checkInt("b2bAckCount", k, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
